// File: rtl/forward_lane_rr_if.sv
// Source heads and the four output buffer ports of one forward lane.
interface forward_lane_rr_if #(
    parameter int PACKET_WIDTH = 30,
    parameter int NUM_IN       = 2,
    parameter int NW           = 21
);
    logic [NUM_IN*PACKET_WIDTH-1:0] din;
    logic [NUM_IN-1:0]              empty_in;
    logic [NUM_IN-1:0]              ren_out;

    logic [PACKET_WIDTH-1:0]        dout_fwd;
    logic                           fwd_empty;
    logic                           ren_fwd;
    logic [NW-1:0]                  dout_north;
    logic                           north_empty;
    logic                           ren_north;
    logic [NW-1:0]                  dout_south;
    logic                           south_empty;
    logic                           ren_south;
    logic [NW-1:0]                  dout_local;
    logic                           local_empty;
    logic                           ren_local;

    modport master (
        output din, empty_in, ren_fwd, ren_north, ren_south, ren_local,
        input  ren_out, dout_fwd, fwd_empty, dout_north, north_empty,
               dout_south, south_empty, dout_local, local_empty
    );

    modport slave (
        input  din, empty_in, ren_fwd, ren_north, ren_south, ren_local,
        output ren_out, dout_fwd, fwd_empty, dout_north, north_empty,
               dout_south, south_empty, dout_local, local_empty
    );
endinterface

// File: rtl/forward_lane_rr.sv
// Round-robin merge of FWFT sources into one stage register, decoded by dx/dy into fwd/north/south/local buffers.
// Head-to-*_empty low in 2 cycles; a stage blocked on a full target halts all grants. Stats: FORWARD_LANE_RR_STATS_EN.
module forward_lane_rr_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign wr_ok    = wr_en_i && !full_o;
    assign rd_ok    = rd_en_i && !empty_o;
    assign rd_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
        if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_dat_i;
    end
endmodule

module forward_lane_rr #(
    parameter int PACKET_WIDTH = 30,
    parameter int DX_MSB       = 29,
    parameter int DX_LSB       = 21,
    parameter int DY_MSB       = 20,
    parameter int DY_LSB       = 12,
    parameter int NUM_IN       = 2,
    parameter int BUFFER_DEPTH = 4,
    parameter int EAST         = 1
) (
    input  logic             clk,
    input  logic             reset,
    forward_lane_rr_if.slave lane
`ifdef FORWARD_LANE_RR_STATS_EN
    ,
    output logic [15:0]      stat_fwd,
    output logic [15:0]      stat_north,
    output logic [15:0]      stat_south,
    output logic [15:0]      stat_local
`endif
);
    localparam int NW  = PACKET_WIDTH - (DX_MSB - DY_MSB);
    localparam int DXW = DX_MSB - DX_LSB + 1;
    localparam int DYW = DY_MSB - DY_LSB + 1;
    localparam int IW  = $clog2(NUM_IN);

    typedef enum logic [1:0] {TGT_FWD, TGT_NORTH, TGT_SOUTH, TGT_LOCAL} tgt_e;

    logic                    stage_vld_q, stage_vld_d;
    logic [PACKET_WIDTH-1:0] stage_q, stage_d;
    logic [IW-1:0]           last_q, last_d;

    logic [IW-1:0]           gnt_idx, cand;
    logic                    gnt_found, gnt_vld, drain;
    logic [NUM_IN-1:0]       ren_vec;

    logic [DXW-1:0]          dx, dx_adj;
    logic [DYW-1:0]          dy;
    logic                    fwd_hit;
    tgt_e                    tgt;
    logic [PACKET_WIDTH-1:0] fwd_pkt;
    logic                    tgt_full;
    logic                    wr_fwd, wr_north, wr_south, wr_local;
    logic                    full_fwd, full_north, full_south, full_local;

    // Round-robin search starting just after the last granted source.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_q;
        cand      = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_IN);
            if (!gnt_found && !lane.empty_in[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign dx      = stage_q[DX_MSB:DX_LSB];
    assign dy      = stage_q[DY_MSB:DY_LSB];
    assign fwd_hit = (EAST != 0) ? (!dx[DXW-1] && (|dx)) : dx[DXW-1];
    assign dx_adj  = (EAST != 0) ? dx - DXW'(1) : dx + DXW'(1);

    always_comb begin
        tgt = TGT_NORTH;
        if (fwd_hit)          tgt = TGT_FWD;
        else if (~|dy)        tgt = TGT_LOCAL;
        else if (dy[DYW-1])   tgt = TGT_SOUTH;
    end

    always_comb begin
        fwd_pkt                  = stage_q;
        fwd_pkt[DX_MSB:DX_LSB]   = dx_adj;
    end

    always_comb begin
        case (tgt)
            TGT_FWD:   tgt_full = full_fwd;
            TGT_NORTH: tgt_full = full_north;
            TGT_SOUTH: tgt_full = full_south;
            default:   tgt_full = full_local;
        endcase
    end

    // Only the selected target's fullness can hold the stage.
    assign drain    = stage_vld_q && !tgt_full;
    assign gnt_vld  = !reset && gnt_found && (!stage_vld_q || drain);
    assign wr_fwd   = drain && (tgt == TGT_FWD);
    assign wr_north = drain && (tgt == TGT_NORTH);
    assign wr_south = drain && (tgt == TGT_SOUTH);
    assign wr_local = drain && (tgt == TGT_LOCAL);

    always_comb begin
        ren_vec = '0;
        if (gnt_vld) ren_vec[gnt_idx] = 1'b1;
    end
    assign lane.ren_out = ren_vec;

    always_comb begin
        stage_vld_d = stage_vld_q;
        stage_d     = stage_q;
        last_d      = last_q;
        if (drain) stage_vld_d = 1'b0;
        if (gnt_vld) begin
            stage_vld_d = 1'b1;
            stage_d     = lane.din[gnt_idx*PACKET_WIDTH +: PACKET_WIDTH];
            last_d      = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_vld_q <= 1'b0;
            stage_q     <= '0;
            last_q      <= IW'(NUM_IN - 1);
        end else begin
            stage_vld_q <= stage_vld_d;
            stage_q     <= stage_d;
            last_q      <= last_d;
        end
    end

    forward_lane_rr_buf #(.WIDTH(PACKET_WIDTH), .DEPTH(BUFFER_DEPTH)) u_buf_fwd (
        .clk(clk), .reset(reset), .wr_en_i(wr_fwd), .wr_dat_i(fwd_pkt),
        .rd_en_i(lane.ren_fwd), .rd_dat_o(lane.dout_fwd),
        .empty_o(lane.fwd_empty), .full_o(full_fwd)
    );

    forward_lane_rr_buf #(.WIDTH(NW), .DEPTH(BUFFER_DEPTH)) u_buf_north (
        .clk(clk), .reset(reset), .wr_en_i(wr_north), .wr_dat_i(stage_q[NW-1:0]),
        .rd_en_i(lane.ren_north), .rd_dat_o(lane.dout_north),
        .empty_o(lane.north_empty), .full_o(full_north)
    );

    forward_lane_rr_buf #(.WIDTH(NW), .DEPTH(BUFFER_DEPTH)) u_buf_south (
        .clk(clk), .reset(reset), .wr_en_i(wr_south), .wr_dat_i(stage_q[NW-1:0]),
        .rd_en_i(lane.ren_south), .rd_dat_o(lane.dout_south),
        .empty_o(lane.south_empty), .full_o(full_south)
    );

    forward_lane_rr_buf #(.WIDTH(NW), .DEPTH(BUFFER_DEPTH)) u_buf_local (
        .clk(clk), .reset(reset), .wr_en_i(wr_local), .wr_dat_i(stage_q[NW-1:0]),
        .rd_en_i(lane.ren_local), .rd_dat_o(lane.dout_local),
        .empty_o(lane.local_empty), .full_o(full_local)
    );

`ifdef FORWARD_LANE_RR_STATS_EN
    logic [3:0]  stat_wr;
    logic [15:0] stat_q [4];

    assign stat_wr = {wr_local, wr_south, wr_north, wr_fwd};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) stat_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (stat_wr[k] && (stat_q[k] != 16'hFFFF)) stat_q[k] <= stat_q[k] + 16'd1;
            end
        end
    end

    assign stat_fwd   = stat_q[0];
    assign stat_north = stat_q[1];
    assign stat_south = stat_q[2];
    assign stat_local = stat_q[3];
`endif
endmodule
